// File: rtl/adpcm_tx_pkg.sv
// Shared types and helpers for the ADPCM serial transmit path.
package adpcm_tx_pkg;

  localparam logic [1:0] RATE_16K = 2'b00;
  localparam logic [1:0] RATE_24K = 2'b01;
  localparam logic [1:0] RATE_32K = 2'b10;
  localparam logic [1:0] RATE_40K = 2'b11;

  typedef struct packed {
    logic       fs;
    logic [1:0] rate;
    logic [4:0] code;
  } tx_entry_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } tx_state_t;

  function automatic logic [2:0] code_len(input logic [1:0] rate);
    return {1'b0, rate} + 3'd2;
  endfunction

endpackage

// File: rtl/adpcm_tx_fifo.sv
// Circular codeword FIFO with wrap-bit pointers; head entry is visible on dout.
module adpcm_tx_fifo
  import adpcm_tx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  tx_entry_t din,
  output tx_entry_t dout,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  tx_entry_t   mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/adpcm_ser_tx.sv
// ADPCM codeword serializer: buffers codes and shifts them out MSB-first
// with a bit-enable strobe and a frame-sync marker on the first bit.
//   state    | meaning
//   ST_IDLE  | line quiet, waiting for a queued code
//   ST_SHIFT | emitting bits of the loaded code, BIT_DIV clk per bit
module adpcm_ser_tx
  import adpcm_tx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int BIT_DIV    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] code_in,
  input  logic       code_valid,
  output logic       code_ready,
  input  logic [1:0] rate,
  input  logic       fs_tag,
  output logic       ser_out,
  output logic       ser_bit_en,
  output logic       ser_fs,
  output logic       busy,
  output logic       ovf,
  input  logic       ovf_clr
);

  localparam int               DIV_W    = $clog2(BIT_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);

  tx_state_t        state, state_nxt;
  tx_entry_t        fifo_din, head;
  logic             full, empty, push, pop;
  logic [2:0]       head_len;
  logic [4:0]       head_aligned;
  logic [4:0]       sreg;
  logic [2:0]       bit_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic             cur_fs, first_bit;
  logic             div_last, last_bit;
  logic             ser_out_d, bit_en_d, fs_d, busy_d;
  logic             unused_code_hi;

  assign unused_code_hi = ^code_in[7:5];

  assign code_ready = !full;
  assign push       = code_valid && !full;
  assign fifo_din   = '{fs: fs_tag, rate: rate, code: code_in[4:0]};

  adpcm_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // Left-align so the MSB of the valid field always leaves from sreg[4].
  assign head_len     = code_len(head.rate);
  assign head_aligned = head.code << (3'd5 - head_len);
  assign div_last     = (div_cnt == DIV_LAST);
  assign last_bit     = (bit_cnt == 3'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (div_last && last_bit) begin
          if (!empty) pop = 1'b1;
          else        state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ser_out_d = 1'b0;
    bit_en_d  = 1'b0;
    fs_d      = 1'b0;
    busy_d    = 1'b0;
    if (state == ST_SHIFT) begin
      ser_out_d = sreg[4];
      bit_en_d  = (div_cnt == '0);
      fs_d      = cur_fs && first_bit;
      busy_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg      <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      cur_fs    <= 1'b0;
      first_bit <= 1'b0;
    end else if (pop) begin
      sreg      <= head_aligned;
      bit_cnt   <= head_len - 3'd1;
      div_cnt   <= '0;
      cur_fs    <= head.fs;
      first_bit <= 1'b1;
    end else if (state == ST_SHIFT) begin
      if (div_last) begin
        div_cnt <= '0;
        if (!last_bit) begin
          sreg      <= {sreg[3:0], 1'b0};
          bit_cnt   <= bit_cnt - 3'd1;
          first_bit <= 1'b0;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // Overflow set takes priority over a coincident clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ser_out    <= 1'b0;
      ser_bit_en <= 1'b0;
      ser_fs     <= 1'b0;
      busy       <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      ser_out    <= ser_out_d;
      ser_bit_en <= bit_en_d;
      ser_fs     <= fs_d;
      busy       <= busy_d;
      if (code_valid && full) ovf <= 1'b1;
      else if (ovf_clr)       ovf <= 1'b0;
    end
  end

endmodule
